multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Control-side counterpart of the CPU datapath core: fetches, decodes and sequences
//  MIPS-subset instructions, producing register selects, immediate, next PC and the
//  per-cycle strobes (regdst, ALUcntrl, ALUsrc, MemWr, RegWr, MemtoReg) the core consumes.
//  Consumes core feedback Da and is_zero to resolve JR and branches.
//  Sits between instruction memory and core; owns the architectural PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  PC_STEP    4              byte increment per sequential instruction
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high reset
//  instr      in   32  instruction word at pc (combinational imem read)
//  Da         in   32  core register-file port A (rs value), used by JR
//  is_zero    in   1   core ALU zero flag, valid during EXEC
//  pc         out  32  current instruction address
//  rd/rt/rs   out  5   register specifiers from latched IR
//  immediate  out  16  IR[15:0]
//  new_PC     out  32  PC+4 value presented to core (JAL link data)
//  regdst     out  2   00=rd, 01=rt, 10=$31
//  ALUcntrl   out  3   000=ADD 001=SUB 010=XOR 011=SLT
//  ALUsrc     out  1   0=register, 1=immediate
//  MemWr      out  1   data-memory write strobe
//  RegWr      out  1   register-file write strobe
//  MemtoReg   out  2   00=memory, 01=ALU, 10=PC+4
//  state      out  3   FSM state (debug)
//  halted     out  1   illegal opcode seen; sticky until reset
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=7. Reset -> FETCH next edge.
//  Reset values: pc=RESET_PC, IR=0, all control outputs 0, MemWr=RegWr=0, halted=0.
//  FETCH: IR<=instr. DECODE: opcode/funct decoded; control fields driven, held stable
//   until instruction retires. MemWr high only in MEM, RegWr only in WB; each 1 cycle.
//  Per-instruction paths and cycle counts (FETCH..retire inclusive):
//   LW  (0x23): F,D,E,M,WB =5; regdst=01 ALUsrc=1 ALU=ADD MemtoReg=00
//   SW  (0x2B): F,D,E,M    =4; ALUsrc=1 ALU=ADD MemWr in MEM
//   ADDI(0x08)/XORI(0x0E): F,D,E,WB =4; regdst=01 ALUsrc=1 MemtoReg=01
//   R-type(0x00) ADD 0x20/SUB 0x22/SLT 0x2A: F,D,E,WB =4; regdst=00 MemtoReg=01
//   JR (R, funct 0x08): F,D,E =3; pc<=Da
//   BNE (0x05): F,D,E =3; ALU=SUB; taken iff is_zero==0
//   J (0x02): F,D =2; JAL (0x03): F,D,WB =3; regdst=10 MemtoReg=10 RegWr in WB
//  PC update at retire edge only: seq=pc+PC_STEP; branch=pc+4+(sext(imm)<<2);
//   jump={pc+4[31:28],IR[25:0],2'b00}; 32-bit wrap-around, no overflow flag.
//  Unknown opcode/funct: DECODE -> HALT, halted=1, strobes 0, pc frozen.
//  Reset mid-instruction wins over any strobe: no MemWr/RegWr on the reset edge's
//   following cycle; partially executed instruction discarded.
//  is_zero sampled only in EXEC of a branch; ignored elsewhere.
// CONFIGURATION
//  SEQUENCER_BEQ_EN defined: BEQ (0x04) supported, F,D,E =3, taken iff is_zero==1.
//  Not defined: opcode 0x04 is illegal -> HALT, halted=1.
// TESTING
//  reset; instr=LW rt=1 rs=0 imm=0 -> states 0,1,2,3,4; RegWr=1 only cycle 5; pc=4 after
//  instr=ADD rd=3 rs=1 rt=2 -> regdst=00 ALUcntrl=000 MemtoReg=01; RegWr in WB; pc+=4
//  instr=SW -> MemWr=1 exactly one cycle in MEM, RegWr never; retire after 4 cycles
//  pc=0x10 BNE imm=0x0003: is_zero=0 -> pc=0x20; is_zero=1 -> pc=0x14
//  pc=0x40 JAL target=0x100 -> regdst=10 MemtoReg=10 new_PC=0x44, pc=0x400
//  opcode 0x3F -> halted=1 stays; BEQ halts iff SEQUENCER_BEQ_EN undefined;
//   reset asserted in MEM of SW -> MemWr=0, state=FETCH, pc=RESET_PC

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle fetch/decode/sequence controller for the MIPS-subset datapath core; owns the PC.
// Optional feature: define SEQUENCER_BEQ_EN to accept BEQ (opcode 0x04); otherwise it halts.
module multicycle_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] Da,
  input  logic        is_zero,
  output logic [31:0] pc,
  output logic [4:0]  rd,
  output logic [4:0]  rt,
  output logic [4:0]  rs,
  output logic [15:0] immediate,
  output logic [31:0] new_PC,
  output logic [1:0]  regdst,
  output logic [2:0]  ALUcntrl,
  output logic        ALUsrc,
  output logic        MemWr,
  output logic        RegWr,
  output logic [1:0]  MemtoReg,
  output logic [2:0]  state,
  output logic        halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    K_LW, K_SW, K_ALUI, K_ALUR, K_JR, K_BNE, K_BEQ, K_J, K_JAL, K_BAD
  } kind_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q;
  logic        halted_q;
  kind_t       kind;
  logic [1:0]  regdst_dec, memtoreg_dec;
  logic [2:0]  alu_dec;
  logic        alusrc_dec;
  logic [5:0]  opcode, funct;
  logic [31:0] pc_plus4, pc_seq, pc_branch, pc_jump;
  logic        active;

  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_seq    = pc_q + PC_STEP;
  assign pc_branch = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign pc_jump   = {pc_plus4[31:28], ir_q[25:0], 2'b00};

  // Decode purely from the latched IR, which is stable from DECODE until retire.
  always_comb begin
    kind         = K_BAD;
    regdst_dec   = 2'b00;
    alu_dec      = 3'b000;
    alusrc_dec   = 1'b0;
    memtoreg_dec = 2'b00;
    case (opcode)
      6'h23: begin kind = K_LW; regdst_dec = 2'b01; alusrc_dec = 1'b1; end
      6'h2B: begin kind = K_SW; alusrc_dec = 1'b1; end
      6'h08: begin kind = K_ALUI; regdst_dec = 2'b01; alusrc_dec = 1'b1; memtoreg_dec = 2'b01; end
      6'h0E: begin
        kind = K_ALUI; regdst_dec = 2'b01; alusrc_dec = 1'b1; memtoreg_dec = 2'b01;
        alu_dec = 3'b010;
      end
      6'h00: begin
        case (funct)
          6'h20: begin kind = K_ALUR; memtoreg_dec = 2'b01; end
          6'h22: begin kind = K_ALUR; memtoreg_dec = 2'b01; alu_dec = 3'b001; end
          6'h2A: begin kind = K_ALUR; memtoreg_dec = 2'b01; alu_dec = 3'b011; end
          6'h08: kind = K_JR;
          default: kind = K_BAD;
        endcase
      end
      6'h05: begin kind = K_BNE; alu_dec = 3'b001; end
`ifdef SEQUENCER_BEQ_EN
      6'h04: begin kind = K_BEQ; alu_dec = 3'b001; end
`endif
      6'h02: kind = K_J;
      6'h03: begin kind = K_JAL; regdst_dec = 2'b10; memtoreg_dec = 2'b10; end
      default: kind = K_BAD;
    endcase
  end

  // The PC only changes on the edge that leaves the last state of an instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (kind)
          K_BAD:   state_d = HALT;
          K_J:     begin state_d = FETCH; pc_d = pc_jump; end
          K_JAL:   state_d = WB;
          default: state_d = EXEC;
        endcase
      end
      EXEC: begin
        case (kind)
          K_LW, K_SW:     state_d = MEM;
          K_ALUI, K_ALUR: state_d = WB;
          K_JR:    begin state_d = FETCH; pc_d = Da; end
          K_BNE:   begin state_d = FETCH; pc_d = is_zero ? pc_seq : pc_branch; end
          K_BEQ:   begin state_d = FETCH; pc_d = is_zero ? pc_branch : pc_seq; end
          default: state_d = HALT;
        endcase
      end
      MEM: begin
        if (kind == K_LW) begin
          state_d = WB;
        end else begin
          state_d = FETCH;
          pc_d    = pc_seq;
        end
      end
      WB: begin
        state_d = FETCH;
        pc_d    = (kind == K_JAL) ? pc_jump : pc_seq;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == FETCH) ir_q <= instr;
      if (state_d == HALT) halted_q <= 1'b1;
    end
  end

  // Strobes are gated by reset so a reset in MEM/WB suppresses the write in that same cycle.
  assign active    = (state_q != FETCH) && (state_q != HALT);
  assign regdst    = active ? regdst_dec : 2'b00;
  assign ALUcntrl  = active ? alu_dec : 3'b000;
  assign ALUsrc    = active ? alusrc_dec : 1'b0;
  assign MemtoReg  = active ? memtoreg_dec : 2'b00;
  assign MemWr     = (state_q == MEM) && (kind == K_SW) && !reset;
  assign RegWr     = (state_q == WB) && !reset;
  assign state     = state_q;
  assign pc        = pc_q;
  assign new_PC    = pc_plus4;
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign immediate = ir_q[15:0];
  assign halted    = halted_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: directed programs push expected events,
// a negedge monitor pops and compares on every strobe, retire and halt.
module tb_multicycle_sequencer;

  localparam int EV_REG  = 0;
  localparam int EV_MEM  = 1;
  localparam int EV_RET  = 2;
  localparam int EV_HALT = 3;

  typedef struct {
    int          kind;
    logic [31:0] pc;
    int          cyc;
    logic [1:0]  rdst;
    logic [2:0]  alu;
    logic        src;
    logic [1:0]  m2r;
    logic [31:0] npc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr, Da;
  logic        is_zero;
  logic [31:0] pc, new_PC;
  logic [4:0]  rd, rt, rs;
  logic [15:0] immediate;
  logic [1:0]  regdst, MemtoReg;
  logic [2:0]  ALUcntrl, state;
  logic        ALUsrc, MemWr, RegWr, halted;

  logic [31:0] imem [0:511];
  logic        zmem [0:511];
  exp_t        exp_q [$];
  bit          mon_en = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  assign instr   = imem[pc[10:2]];
  assign is_zero = zmem[pc[10:2]];
  assign Da      = 32'h0000_0050;

  multicycle_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .Da(Da), .is_zero(is_zero),
    .pc(pc), .rd(rd), .rt(rt), .rs(rs), .immediate(immediate), .new_PC(new_PC),
    .regdst(regdst), .ALUcntrl(ALUcntrl), .ALUsrc(ALUsrc), .MemWr(MemWr),
    .RegWr(RegWr), .MemtoReg(MemtoReg), .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic reportBad(input string name, input int got);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: actual=%0d required=0", name, got);
  endtask

  task automatic pushExp(input int kind, input logic [31:0] epc, input int cyc,
                         input logic [1:0] rdst, input logic [2:0] alu, input logic src,
                         input logic [1:0] m2r, input logic [31:0] npc);
    exp_t e;
    e.kind = kind; e.pc = epc; e.cyc = cyc; e.rdst = rdst;
    e.alu = alu; e.src = src; e.m2r = m2r; e.npc = npc;
    exp_q.push_back(e);
  endtask

  task automatic expReg(input logic [1:0] rdst, input logic [2:0] alu, input logic src,
                        input logic [1:0] m2r, input logic [31:0] npc);
    pushExp(EV_REG, 32'd0, 0, rdst, alu, src, m2r, npc);
  endtask

  task automatic expRet(input logic [31:0] epc, input int cyc);
    pushExp(EV_RET, epc, cyc, 2'b00, 3'b000, 1'b0, 2'b00, 32'd0);
  endtask

  task automatic clearProgram(input logic zdef);
    for (int i = 0; i < 512; i++) begin
      imem[i] = 32'hFC00_0000;
      zmem[i] = zdef;
    end
  endtask

  task automatic loadWord(input logic [31:0] addr, input logic [31:0] word, input logic z);
    imem[addr[10:2]] = word;
    zmem[addr[10:2]] = z;
  endtask

  task automatic resetDut();
    mon_en = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic applyStimulus(input string phase, input int budget);
    int waited;
    waited = 0;
    resetDut();
    mon_en = 1'b1;
    while (exp_q.size() != 0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (exp_q.size() != 0) begin
      reportBad({phase, " timeout outstanding events"}, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: pops one expectation per observed DUT event.
  initial begin
    logic [2:0] prev_state;
    logic       prev_halt;
    int         cyc;
    int         idx;
    exp_t       e;
    idx = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_state = 3'd0;
        prev_halt  = 1'b0;
        cyc        = 0;
      end else begin
        if (MemWr || RegWr) begin
          if (exp_q.size() == 0) begin
            reportBad($sformatf("ev%0d unexpected strobe at pc 0x%08h", idx, pc), 1);
          end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("ev%0d strobe kind", idx), MemWr ? EV_MEM : EV_REG, e.kind);
            checkOutput($sformatf("ev%0d both strobes", idx), {31'd0, MemWr & RegWr}, 32'd0);
            checkOutput($sformatf("ev%0d ALUcntrl", idx), ALUcntrl, e.alu);
            checkOutput($sformatf("ev%0d ALUsrc", idx), ALUsrc, e.src);
            if (e.kind == EV_REG) begin
              checkOutput($sformatf("ev%0d state", idx), state, 3'd4);
              checkOutput($sformatf("ev%0d regdst", idx), regdst, e.rdst);
              checkOutput($sformatf("ev%0d MemtoReg", idx), MemtoReg, e.m2r);
              checkOutput($sformatf("ev%0d new_PC", idx), new_PC, e.npc);
            end else begin
              checkOutput($sformatf("ev%0d state", idx), state, 3'd3);
            end
          end
          idx++;
        end
        if (state == 3'd0 && prev_state != 3'd0) begin
          if (exp_q.size() == 0) begin
            reportBad($sformatf("ev%0d unexpected retire to pc 0x%08h", idx, pc), 1);
          end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("ev%0d retire kind", idx), EV_RET, e.kind);
            checkOutput($sformatf("ev%0d retire pc", idx), pc, e.pc);
            checkOutput($sformatf("ev%0d retire cycles", idx), cyc, e.cyc);
          end
          idx++;
          cyc = 1;
        end else begin
          cyc++;
        end
        if (halted && !prev_halt) begin
          if (exp_q.size() == 0) begin
            reportBad($sformatf("ev%0d unexpected halt at pc 0x%08h", idx, pc), 1);
          end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("ev%0d halt kind", idx), EV_HALT, e.kind);
            checkOutput($sformatf("ev%0d halt pc", idx), pc, e.pc);
            checkOutput($sformatf("ev%0d halt state", idx), state, 3'd7);
          end
          idx++;
        end
        prev_state = state;
        prev_halt  = halted;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    $display("[TB] starting");
    clearProgram(1'b1);
    loadWord(32'h0, 32'h8C01_0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", state, 3'd0);
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset RegWr", RegWr, 0);
    checkOutput("reset MemWr", MemWr, 0);
    checkOutput("reset regdst", regdst, 0);
    checkOutput("reset ALUcntrl", ALUcntrl, 0);
    checkOutput("reset ALUsrc", ALUsrc, 0);
    checkOutput("reset MemtoReg", MemtoReg, 0);
    checkOutput("reset halted", halted, 0);
    checkOutput("reset IR fields", {rs, rt, rd, immediate}, 32'h0);
    checkOutput("reset new_PC", new_PC, 32'h4);

    // Phase 1: main instruction mix ending in an illegal funct.
    clearProgram(1'b1);
    loadWord(32'h000, 32'h8C01_0000, 1'b1);  expReg(2'b01, 3'b000, 1'b1, 2'b00, 32'h04); expRet(32'h04, 5);
    loadWord(32'h004, 32'h0022_1820, 1'b1);  expReg(2'b00, 3'b000, 1'b0, 2'b01, 32'h08); expRet(32'h08, 4);
    loadWord(32'h008, 32'hAC02_0008, 1'b1);
    pushExp(EV_MEM, 32'd0, 0, 2'b00, 3'b000, 1'b1, 2'b00, 32'd0);                     expRet(32'h0C, 4);
    loadWord(32'h00C, 32'h0022_2022, 1'b1);  expReg(2'b00, 3'b001, 1'b0, 2'b01, 32'h10); expRet(32'h10, 4);
    loadWord(32'h010, 32'h1422_0003, 1'b0);                                             expRet(32'h20, 3);
    loadWord(32'h020, 32'h2005_0007, 1'b1);  expReg(2'b01, 3'b000, 1'b1, 2'b01, 32'h24); expRet(32'h24, 4);
    loadWord(32'h024, 32'h38A6_00FF, 1'b1);  expReg(2'b01, 3'b010, 1'b1, 2'b01, 32'h28); expRet(32'h28, 4);
    loadWord(32'h028, 32'h0022_382A, 1'b1);  expReg(2'b00, 3'b011, 1'b0, 2'b01, 32'h2C); expRet(32'h2C, 4);
    loadWord(32'h02C, 32'h0800_0010, 1'b1);                                             expRet(32'h40, 2);
    loadWord(32'h040, 32'h0C00_0100, 1'b1);  expReg(2'b10, 3'b000, 1'b0, 2'b10, 32'h44); expRet(32'h400, 3);
    loadWord(32'h400, 32'h03E0_0008, 1'b1);                                             expRet(32'h50, 3);
    loadWord(32'h050, 32'h0000_003F, 1'b1);
    pushExp(EV_HALT, 32'h50, 0, 2'b00, 3'b000, 1'b0, 2'b00, 32'd0);
    applyStimulus("main", 300);
    repeat (4) @(negedge clk);
    checkOutput("halt sticky", halted, 1);
    checkOutput("halt pc frozen", pc, 32'h50);
    checkOutput("halt state", state, 3'd7);
    checkOutput("halt strobes", {RegWr, MemWr}, 0);

    // Phase 2: BNE not taken when is_zero=1, then opcode 0x3F.
    clearProgram(1'b0);
    loadWord(32'h000, 32'h0800_0004, 1'b0);  expRet(32'h10, 2);
    loadWord(32'h010, 32'h1422_0003, 1'b1);  expRet(32'h14, 3);
    loadWord(32'h014, 32'hFC00_0000, 1'b0);
    pushExp(EV_HALT, 32'h14, 0, 2'b00, 3'b000, 1'b0, 2'b00, 32'd0);
    applyStimulus("bne", 100);

    // Phase 3: BEQ, present only in the configured build.
    clearProgram(1'b0);
    loadWord(32'h000, 32'h1000_0002, 1'b1);
`ifdef SEQUENCER_BEQ_EN
    expRet(32'h0C, 3);
    pushExp(EV_HALT, 32'h0C, 0, 2'b00, 3'b000, 1'b0, 2'b00, 32'd0);
`else
    pushExp(EV_HALT, 32'h00, 0, 2'b00, 3'b000, 1'b0, 2'b00, 32'd0);
`endif
    applyStimulus("beq", 100);

    // Phase 4: reset while SW sits in MEM.
    clearProgram(1'b0);
    loadWord(32'h000, 32'hAC02_0008, 1'b0);
    resetDut();
    expRet(32'h0, 4);
    mon_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (state == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) reportBad("reset-in-MEM timeout waiting for MEM", 1);
    reset = 1'b1;
    #1;
    checkOutput("MemWr under reset", MemWr, 0);
    checkOutput("RegWr under reset", RegWr, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("post-reset state", state, 3'd0);
    checkOutput("post-reset pc", pc, 32'h0);
    checkOutput("post-reset MemWr", MemWr, 0);
    checkOutput("post-reset halted", halted, 0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset retire consumed", exp_q.size(), 0);
    mon_en = 1'b0;
    exp_q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
